// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single memory port shared by fetch (0), load (1) and store (2).
// Sequences start / wait-for-ready / done, with a watchdog that aborts stuck accesses.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       mem_ready_i,
  output logic [1:0] sel_o,
  output logic [2:0] grant_o,
  output logic       mem_start_o,
  output logic [2:0] done_o,
  output logic       err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_grant;
  logic [1:0]       p0, p1, p2, pick;

  // Search order starts just after the most recently served requester.
  always_comb begin
    case (last_grant)
      2'd0:    {p0, p1, p2} = {2'd1, 2'd2, 2'd0};
      2'd1:    {p0, p1, p2} = {2'd2, 2'd0, 2'd1};
      default: {p0, p1, p2} = {2'd0, 2'd1, 2'd2};
    endcase
    if (req_i[p0])      pick = p0;
    else if (req_i[p1]) pick = p1;
    else                pick = p2;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      sel_o       <= 2'b00;
      grant_o     <= 3'b000;
      mem_start_o <= 1'b0;
      done_o      <= 3'b000;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      cnt         <= '0;
      last_grant  <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 3'b000;
          err_o  <= 1'b0;
          if (|req_i) begin
            grant_o     <= 3'b001 << pick;
            sel_o       <= pick;
            mem_start_o <= 1'b1;
            busy_o      <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end else begin
            grant_o     <= 3'b000;
            sel_o       <= 2'b00;
            mem_start_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        BUSY: begin
          mem_start_o <= 1'b0;
          cnt         <= cnt + 1'b1;
          // A ready in the final watchdog cycle still counts as a clean completion.
          if (mem_ready_i || cnt == CNT_W'(TIMEOUT - 1)) begin
            done_o     <= grant_o;
            err_o      <= ~mem_ready_i;
            grant_o    <= 3'b000;
            last_grant <= sel_o;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          done_o <= 3'b000;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic       ready = 1'b0;
  logic [1:0] sel_o;
  logic [2:0] grant_o, done_o;
  logic       mem_start_o, err_o, busy_o;

  int checks = 0;
  int errors = 0;

  // model: who owns the port, who is being told "done", how long the owner has waited
  int         m_owner = -1;
  int         m_done  = -1;
  int         m_waited = 0;
  int         m_last  = 2;
  logic       m_err   = 1'b0;
  logic       m_start = 1'b0;
  logic [1:0] m_sel   = 2'b00;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .mem_ready_i(ready),
    .sel_o(sel_o), .grant_o(grant_o), .mem_start_o(mem_start_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {sel_o, grant_o, mem_start_o, done_o, err_o, busy_o};
  endfunction

  function automatic logic [10:0] vec(input logic [1:0] s, input logic [2:0] g, input logic st,
                                      input logic [2:0] d, input logic e, input logic b);
    return {s, g, st, d, e, b};
  endfunction

  function automatic logic [10:0] model_exp();
    logic [2:0] g, d;
    g = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    d = (m_done  >= 0) ? (3'b001 << m_done)  : 3'b000;
    return {m_sel, g, m_start, d, m_err, (m_owner >= 0) || (m_done >= 0)};
  endfunction

  task automatic model_update();
    int c;
    bit found;
    if (!rst) begin
      m_owner = -1; m_done = -1; m_err = 1'b0; m_start = 1'b0; m_last = 2; m_sel = 2'b00;
    end else if (m_owner >= 0) begin
      m_start = 1'b0;
      m_waited++;
      if (ready || m_waited == TIMEOUT) begin
        m_done = m_owner; m_err = !ready; m_last = m_owner; m_owner = -1;
      end
    end else if (m_done >= 0) begin
      m_done = -1; m_err = 1'b0;
    end else if (req != 3'b000) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (!found && req[c]) begin m_owner = c; found = 1; end
      end
      m_waited = 0; m_start = 1'b1; m_sel = 2'(m_owner);
    end else begin
      m_sel = 2'b00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 3'b000; ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL reset_state got %b want %b", obs(), 11'd0);
    end
  endtask

  task automatic test_single_load();
    req = 3'b010;
    tick();
    checks++;
    if (obs() !== vec(2'b01, 3'b010, 1'b1, 3'b000, 1'b0, 1'b1)) begin
      errors++; $display("FAIL load_grant got %b", obs());
    end
    tick(); tick(); tick();
    checks++;
    if (obs() !== vec(2'b01, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1)) begin
      errors++; $display("FAIL load_hold got %b", obs());
    end
    ready = 1'b1;
    tick();
    ready = 1'b0; req = 3'b000;
    checks++;
    if (obs() !== vec(2'b01, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1)) begin
      errors++; $display("FAIL load_done got %b", obs());
    end
    tick();
    checks++;
    if (obs() !== vec(2'b01, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0)) begin
      errors++; $display("FAIL load_done_once got %b", obs());
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    do_reset();
    req = 3'b111; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = 3'b001 << (i % 3);
      tick();
      checks++;
      if (obs() !== vec(2'(i % 3), g, 1'b1, 3'b000, 1'b0, 1'b1)) begin
        errors++; $display("FAIL rr_grant%0d got %b want grant %b", i, obs(), g);
      end
      tick();
      checks++;
      if (done_o !== g || grant_o !== 3'b000) begin
        errors++; $display("FAIL rr_done%0d got done %b grant %b want done %b", i, done_o, grant_o, g);
      end
      tick();
      checks++;
      if (grant_o !== 3'b000 || done_o !== 3'b000) begin
        errors++; $display("FAIL rr_gap%0d got grant %b done %b want 0", i, grant_o, done_o);
      end
    end
    req = 3'b000; ready = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b100;
    tick();
    for (int k = 2; k <= TIMEOUT; k++) begin
      tick();
      checks++;
      if (grant_o !== 3'b100 || done_o !== 3'b000 || sel_o !== 2'b10) begin
        errors++; $display("FAIL to_hold%0d got grant %b done %b sel %b", k, grant_o, done_o, sel_o);
      end
    end
    tick();
    req = 3'b000;
    checks++;
    if (obs() !== vec(2'b10, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1)) begin
      errors++; $display("FAIL to_abort got %b", obs());
    end
    tick();
    checks++;
    if (obs() !== vec(2'b10, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0)) begin
      errors++; $display("FAIL to_idle got %b", obs());
    end
  endtask

  task automatic test_ready_at_limit();
    req = 3'b001;
    tick();
    for (int k = 2; k <= TIMEOUT; k++) tick();
    checks++;
    if (grant_o !== 3'b001 || done_o !== 3'b000) begin
      errors++; $display("FAIL lim_hold got grant %b done %b", grant_o, done_o);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0; req = 3'b000;
    checks++;
    if (obs() !== vec(2'b00, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1)) begin
      errors++; $display("FAIL lim_ready_wins got %b", obs());
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 3'b001;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL rst_busy got %b want %b", obs(), 11'd0);
    end
    rst = 1'b1; req = 3'b011;
    tick();
    checks++;
    if (obs() !== vec(2'b00, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1)) begin
      errors++; $display("FAIL rst_regrant got %b", obs());
    end
    ready = 1'b1;
    tick();
    ready = 1'b0; req = 3'b000;
    tick();
  endtask

  task automatic test_drop_req();
    req = 3'b001;
    tick(); tick();
    req = 3'b000;
    tick(); tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (done_o !== 3'b001 || err_o !== 1'b0) begin
      errors++; $display("FAIL drop_done got done %b err %b want 001 0", done_o, err_o);
    end
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    checks++;
    if (obs() !== 11'd0) begin
      errors++; $display("FAIL idle_ready_ignored got %b want %b", obs(), 11'd0);
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    thr = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) thr = (cyc / 250) % 3 == 0 ? 30 : ((cyc / 250) % 3 == 1 ? 3 : 0);
      rst   = ($urandom_range(0, 199) != 0);
      req   = 3'($urandom_range(0, 7));
      ready = ($urandom_range(0, 99) < thr);
      tick();
      checks++;
      if (obs() !== model_exp()) begin
        errors++; $display("FAIL rand_cyc%0d got %b want %b", cyc, obs(), model_exp());
      end
      checks++;
      if (sel_o === 2'b11 || (grant_o & (grant_o - 3'b001)) !== 3'b000 || (done_o & grant_o) !== 3'b000) begin
        errors++; $display("FAIL rand_invariant%0d got sel %b grant %b done %b", cyc, sel_o, grant_o, done_o);
      end
    end
    rst = 1'b1; req = 3'b000; ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_busy();
    test_drop_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
